// File: rtl/stopwatch_counter.sv
// BCD stopwatch time base: mm:ss.cc counter with a run-gated prescaler,
// clear, and a lap freeze that latches the displayed value while counting continues.
module stopwatch_counter #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] cs_ones,
    output logic [3:0] cs_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       frozen,
    output logic       tick,
    output logic       wrap
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [23:0] TIME_MAX = 24'h595999;

    // Digit packing, LSB first: cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   live_q, live_d;
    logic [23:0]   lat_q, lat_d;
    logic          frozen_q, frozen_d;
    logic [23:0]   disp;
    logic          cy;
    logic [3:0]    dig;
    logic [3:0]    lim;

    assign tick = run & (presc_q == PMAX) & ~clear;
    assign wrap = tick & (live_q == TIME_MAX);

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
        end
    end

    // Ripple the carry from centiseconds upward; tens of seconds/minutes roll at 5.
    always_comb begin
        live_d = live_q;
        cy     = tick;
        dig    = '0;
        lim    = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            dig = live_q[4*i +: 4];
            lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
            if (cy) begin
                if (dig == lim) begin
                    live_d[4*i +: 4] = '0;
                end else begin
                    live_d[4*i +: 4] = dig + 4'd1;
                    cy = 1'b0;
                end
            end
        end
        if (clear) begin
            live_d = '0;
        end
    end

    // Latch captures the pre-edge live value, so a coincident tick is not included.
    always_comb begin
        lat_d    = lat_q;
        frozen_d = frozen_q;
        if (clear) begin
            lat_d    = '0;
            frozen_d = 1'b0;
        end else if (lap) begin
            if (!frozen_q) begin
                lat_d    = live_q;
                frozen_d = 1'b1;
            end else begin
                frozen_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            live_q   <= '0;
            lat_q    <= '0;
            frozen_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            live_q   <= live_d;
            lat_q    <= lat_d;
            frozen_q <= frozen_d;
        end
    end

    always_comb begin
        disp = frozen_q ? lat_q : live_q;
    end

    assign cs_ones  = disp[3:0];
    assign cs_tens  = disp[7:4];
    assign sec_ones = disp[11:8];
    assign sec_tens = disp[15:12];
    assign min_ones = disp[19:16];
    assign min_tens = disp[23:20];
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter (DIV = 10): expected tick events are queued
// by the stimulus and matched by a monitor; display state is checked at fixed points.
module tb_stopwatch_counter;

    typedef struct {
        int unsigned cyc;
        logic        wrap;
    } tick_exp_t;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       clear;
    logic       lap;
    logic [3:0] cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens;
    logic       frozen;
    logic       tick;
    logic       wrap;

    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;
    tick_exp_t   exp_q[$];
    int unsigned p, q, r, w, y, z;

    stopwatch_counter #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .clear    (clear),
        .lap      (lap),
        .cs_ones  (cs_ones),
        .cs_tens  (cs_tens),
        .sec_ones (sec_ones),
        .sec_tens (sec_tens),
        .min_ones (min_ones),
        .min_tens (min_tens),
        .frozen   (frozen),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_disp(input string name, input logic [23:0] exp, input logic exp_fz);
        check({name, "_digits"},
              {8'h0, min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}, {8'h0, exp});
        check({name, "_frozen"}, {31'h0, frozen}, {31'h0, exp_fz});
    endtask

    task automatic push_tick(input int unsigned c, input logic wr);
        tick_exp_t e;
        e.cyc  = c;
        e.wrap = wr;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name);
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every tick must match the next queued expectation.
    always @(negedge clk) begin
        if (tick) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", cyc, 32'hFFFF_FFFF);
            end else begin
                tick_exp_t e;
                e = exp_q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_wrap", {31'h0, wrap}, {31'h0, e.wrap});
            end
        end else if (wrap) begin
            check("wrap_without_tick", {31'h0, wrap}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        clear = 1'b0;
        lap   = 1'b0;
        step(3);
        check_disp("reset", 24'h0, 1'b0);
        check("reset_tick", {31'h0, tick}, 32'd0);
        check("reset_wrap", {31'h0, wrap}, 32'd0);

        // 1: free run from reset
        rst_n = 1'b1;
        run   = 1'b1;
        p = cyc;
        for (int unsigned k = 1; k <= 10; k++) push_tick(p + 10*k - 1, 1'b0);
        step(100);
        run = 1'b0;
        check_disp("t1_count", 24'h000010, 1'b0);
        check_drained("t1_drain");

        // 2: pause keeps the partial interval
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_disp("t2_clear", 24'h0, 1'b0);
        run = 1'b1;
        q = cyc;
        step(4);
        run = 1'b0;
        step(50);
        run = 1'b1;
        r = cyc;
        push_tick(r + 5, 1'b0);
        step(6);
        run = 1'b0;
        check_disp("t2_resume", 24'h000001, 1'b0);
        check("t2_pause_len", r - q, 32'd54);
        check_drained("t2_drain");

        // 3: preload to the maximum and roll over
        force dut.live_q = 24'h595999;
        step(1);
        release dut.live_q;
        check_disp("t3_preload", 24'h595999, 1'b0);
        run = 1'b1;
        w = cyc;
        push_tick(w + 9, 1'b1);
        push_tick(w + 19, 1'b0);
        step(10);
        check_disp("t3_wrapped", 24'h0, 1'b0);
        step(10);
        check_disp("t3_continue", 24'h000001, 1'b0);
        run = 1'b0;
        check_drained("t3_drain");

        // 4: lap coincident with a tick
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_disp("t4_clear", 24'h0, 1'b0);
        run = 1'b1;
        y = cyc;
        for (int unsigned k = 1; k <= 36; k++) push_tick(y + 10*k - 1, 1'b0);
        push_tick(y + 379, 1'b0);
        step(59);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_disp("t4_lap_hold", 24'h000005, 1'b1);
        step(300);
        check_disp("t4_still_held", 24'h000005, 1'b1);
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_disp("t4_unfreeze", 24'h000036, 1'b0);

        // 5: clear + lap + tick together while frozen
        lap = 1'b1;
        step(1);
        lap = 1'b0;
        check_disp("t5_refreeze", 24'h000036, 1'b1);
        step(7);
        clear = 1'b1;
        lap   = 1'b1;
        step(1);
        clear = 1'b0;
        lap   = 1'b0;
        check_disp("t5_clear_all", 24'h0, 1'b0);
        step(10);
        check_disp("t5_next_tick", 24'h000001, 1'b0);
        check_drained("t5_drain");

        // 6: asynchronous reset between edges
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_disp("t6_async_reset", 24'h0, 1'b0);
        check("t6_tick", {31'h0, tick}, 32'd0);
        check("t6_wrap", {31'h0, wrap}, 32'd0);
        step(2);
        rst_n = 1'b1;
        z = cyc;
        push_tick(z + 9, 1'b0);
        step(10);
        check_disp("t6_after_reset", 24'h000001, 1'b0);
        run = 1'b0;
        step(2);
        check_drained("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
